// File: rtl/sdp_mrdma_eg_din_sfifo.sv
// Flop-based valid/ready FIFO between the MRDMA egress unpacker and the egress consumer.
// Latency: a write is visible on rd_pd one cycle after it is accepted; no write-to-read bypass.
// Backpressure: wr_prdy drops when the registered count is full, independent of rd_prdy.
module sdp_mrdma_eg_din_sfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pwrbus_ram_pd,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CW-1:0]    wr_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_acc;
  logic             rd_acc;
  logic             unused_pwrbus;

  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Full refuses writes even when a read drains an entry in the same cycle.
  assign wr_prdy  = (count != CW'(DEPTH)) & ~reset;
  assign rd_pvld  = (count != '0);
  assign rd_pd    = mem[rd_ptr];
  assign wr_count = count;
  assign wr_acc   = wr_pvld & wr_prdy;
  assign rd_acc   = rd_pvld & rd_prdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_pd;
    end
  end

endmodule

// File: doc/sdp_mrdma_eg_din_sfifo.md
# sdp_mrdma_eg_din_sfifo

Synchronous valid/ready FIFO on the SDP MRDMA egress data-in path, 256-bit payload, configurable depth. Owns write/read pointers, occupancy and flow control, and holds its entries in flop storage: write-enable on accept, read by pointer mux. Sits between the MRDMA egress unpacker (upstream, write side) and the egress command/data consumer (downstream, read side). It smooths bursts so the unpacker can stall independently of the consumer.

## Interface
Parameters:
- DEPTH, 4, number of entries; any integer 2..16, not required to be a power of two.
- WIDTH, 256, payload width in bits.
- CW, derived = clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pwrbus_ram_pd  in  32  RAM power-down bus; accepted and unused, no functional effect.
- wr_pvld  in  1  upstream write valid.
- wr_prdy  out  1  FIFO can accept a write this cycle.
- wr_pd  in  WIDTH  write payload.
- rd_pvld  out  1  FIFO holds at least one entry.
- rd_prdy  in  1  downstream accepts the head entry.
- rd_pd  out  WIDTH  head entry payload.
- wr_count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Write accept: wr_acc = wr_pvld & wr_prdy. Stores wr_pd at entry wr_ptr and advances wr_ptr.
- Read accept: rd_acc = rd_pvld & rd_prdy. Advances rd_ptr.
- Pointers are 0..DEPTH-1 and wrap from DEPTH-1 to 0. Explicit compare, no power-of-two masking.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Count never exceeds DEPTH and never goes below 0.
- wr_prdy = (count != DEPTH) & !reset. Derived from registered count only, never from rd_prdy. A full FIFO refuses a write even when a read occurs in the same cycle.
- rd_pvld = (count != 0). rd_pd = storage[rd_ptr], a combinational mux from flops.
- No write-to-read bypass. Data written in cycle N is first visible on rd_pd in cycle N+1.
- Simultaneous wr_acc and rd_acc at any non-full, non-empty count: both complete and count is unchanged.
- Simultaneous wr_acc and rd_acc with count=1: both complete; the new entry becomes head next cycle.
- rd_pd is don't-care while rd_pvld=0. Storage flops are not reset.
- wr_pvld/wr_pd may change while wr_prdy=0; nothing is stored.
- rd_prdy while rd_pvld=0 is ignored.

## Timing
- Reset (any cycle, including mid-stream): the next edge sets wr_ptr=0, rd_ptr=0, count=0.
  - Contents are discarded; in-flight entries are lost.
  - While reset=1: wr_prdy=0 and writes are ignored.
  - After the first edge with reset=1: rd_pvld=0 and wr_count=0.
- First cycle after reset deasserts: wr_prdy=1, rd_pvld=0.
- Write-to-read latency: 1 cycle.
- Full-to-ready latency: 1 cycle after a rd_acc from count=DEPTH, wr_prdy returns to 1.
- Sustained throughput: one write and one read per cycle when 0 < count < DEPTH.
- Outputs rd_pvld, wr_prdy (apart from its reset term) and wr_count are functions of registers only. rd_pd depends on registers only.

## Test plan
- Reset then single write: wr_pd=256'hA5..A5 at cycle 0 -> rd_pvld=1 and rd_pd=A5..A5 at cycle 1; wr_count 0->1.
- Fill DEPTH=4 with 1,2,3,4 while rd_prdy=0 -> wr_prdy=0 after the 4th accept and wr_count=4. A 5th write with value 5 is refused. Drain yields 1,2,3,4 in order, then rd_pvld=0.
- Full plus simultaneous read: count=4, wr_pvld=1 and rd_prdy=1 -> only the read completes; count=3; next cycle wr_prdy=1 and the write is accepted.
- Streaming wrap: 20 back-to-back writes with rd_prdy=1 from the cycle after the first write -> 20 reads in order, count holds at 1. Pointers wrap five times with DEPTH=4; repeat with DEPTH=3.
- Reset mid-operation: count=3, assert reset for 1 cycle -> next cycle rd_pvld=0, wr_count=0. After deassert, a new write of 0x77 is read back as the sole entry.
- Random wr_pvld/rd_prdy for 10k cycles against a scoreboard model -> no loss, no duplication, ordering preserved, 0 <= wr_count <= DEPTH every cycle.
